hpdc_mem_req_arbiter: RTL and testbench
=======================================

Name: hpdc_mem_req_arbiter

Overview:
- Shares the single HPDcache memory read-request channel between two requesters, e.g. the data-cache miss handler and a prefetcher or the I$ refill path.
- Performs round-robin arbitration and registers the granted request in a 1-entry output stage.
- Tags each transaction ID with the requester index and tracks outstanding transactions per requester.
- Routes read-response beats back to the owning requester by ID MSB.

Parameters:
- ADDR_WIDTH, 40: physical address width; equals the HPDcache PA width.
- ID_WIDTH, 8: memory transaction ID width. Requester-side ID width is ID_WIDTH-1.
- DATA_WIDTH, 512: memory response data width (8 words of 64 bit).
- MAX_OUTSTANDING, 8: maximum in-flight transactions per requester, 1..2^(ID_WIDTH-1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req0_valid_i / req1_valid_i  in  1  requester N request valid
- req0_ready_o / req1_ready_o  out  1  requester N request accepted
- req0_addr_i / req1_addr_i  in  ADDR_WIDTH  request address
- req0_len_i / req1_len_i  in  8  beats minus 1
- req0_size_i / req1_size_i  in  3  log2 of bytes per beat
- req0_id_i / req1_id_i  in  ID_WIDTH-1  requester-local ID
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request ready
- mem_req_addr_o  out  ADDR_WIDTH  forwarded address
- mem_req_len_o  out  8  forwarded length
- mem_req_size_o  out  3  forwarded size
- mem_req_id_o  out  ID_WIDTH  {requester index, local ID}
- mem_resp_valid_i  in  1  response beat valid
- mem_resp_ready_o  out  1  response beat ready
- mem_resp_id_i  in  ID_WIDTH  response ID
- mem_resp_data_i  in  DATA_WIDTH  response data
- mem_resp_last_i  in  1  final beat
- mem_resp_error_i  in  1  bus error
- resp0_valid_o / resp1_valid_o  out  1  routed beat valid
- resp0_ready_i / resp1_ready_i  in  1  requester N beat ready
- resp0_id_o / resp1_id_o  out  ID_WIDTH-1  local ID (MSB stripped)
- resp0_data_o / resp1_data_o  out  DATA_WIDTH  data
- resp0_last_o / resp1_last_o  out  1  last
- resp0_error_o / resp1_error_o  out  1  error
- idle_o  out  1  no pending request, all counters 0
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values:
  - mem_req_valid_o=0; all mem_req_* fields 0.
  - Both outstanding counters 0; rr pointer=0 (requester 0 has priority).
  - err_o=0; idle_o=1.
- Eligibility and slot:
  - elig_N = reqN_valid_i & (cnt_N < MAX_OUTSTANDING).
  - slot_free = !mem_req_valid_o | mem_req_ready_i.
- Grant:
  - Exactly one eligible requester: it is granted.
  - Both eligible: requester rr is granted.
  - reqN_ready_o = grant_N & slot_free.
  - On fire: rr <= other index; output register loads addr/len/size and id={N, reqN_id_i}; mem_req_valid_o <= 1.
  - Latency: accept at cycle T gives mem_req_valid_o at T+1.
- Output stage:
  - Fields are held stable while mem_req_valid_o=1 and mem_req_ready_i=0.
  - If it drains with no new grant, mem_req_valid_o <= 0.
  - Back-to-back drain and reload in the same cycle is supported, giving full throughput.
- Counters:
  - cnt_N increments on reqN fire.
  - cnt_N decrements on a response beat fire with last=1 and ID MSB=N.
  - Simultaneous increment and decrement leave the count unchanged.
  - Counter width is clog2(MAX_OUTSTANDING+1).
- Response routing (combinational, zero latency):
  - sel = mem_resp_id_i[ID_WIDTH-1].
  - resp_sel_valid_o = mem_resp_valid_i; the other requester's valid is 0.
  - mem_resp_ready_o = resp_sel_ready_i.
  - data, last and error pass through unchanged; id is the low ID_WIDTH-1 bits.
- Error conditions:
  - A last-beat response fire to a requester with cnt=0 leaves the counter at 0, sets err_o, and still delivers the beat.
  - err_o clears only on reset.
  - mem_resp_error_i does not set err_o; it is forwarded only.
- idle_o = !mem_req_valid_o & cnt_0==0 & cnt_1==0.
- Reset mid-operation:
  - Any pending output request and all counts are discarded.
  - Late responses to pre-reset transactions then set err_o.

Test Plan:
- req0 only, addr 0x8000_0040, id 0x05, len 0 -> at T+1 mem_req_valid_o=1, mem_req_id_o=0x05. Then req1 id 0x12 -> mem_req_id_o=0x92.
- Both requesters held valid, mem_req_ready_i=1 -> grants alternate 0,1,0,1 starting with 0 after reset; one request issued per cycle.
- mem_req_ready_i=0 for 5 cycles with a request pending -> mem_req_* fields stable and both req ready=0. Ready then raised -> drains, next grant the same cycle.
- req0 issues 8 requests with no responses -> req0_ready_o=0 while req1 is still served. Response id 0x03 with last=1 -> req0 accepted the following cycle.
- 4-beat response with id 0x83 while resp1_ready_i toggles 1,0,1 -> beats appear only on resp1 with id 0x03. cnt_1 decrements once, on the last fire.
- Last-beat response with id 0x01 while cnt_0=0 -> err_o=1 and the beat is delivered; err_o stays 1 until rst_i.

Source files
------------

// File: rtl/hpdc_mem_req_arbiter.sv
// Two-requester arbiter for the HPDcache memory read-request channel.
// Round-robin grant into a 1-entry registered output stage; the requester
// index is carried in the ID MSB and used to route response beats back.
// Per-requester outstanding counters throttle requesters and flag
// responses that arrive for a requester with nothing in flight.
module hpdc_mem_req_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 40,
    parameter int unsigned ID_WIDTH        = 8,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [7:0]            req0_len_i,
    input  logic [2:0]            req0_size_i,
    input  logic [ID_WIDTH-2:0]   req0_id_i,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [7:0]            req1_len_i,
    input  logic [2:0]            req1_size_i,
    input  logic [ID_WIDTH-2:0]   req1_id_i,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [7:0]            mem_req_len_o,
    output logic [2:0]            mem_req_size_o,
    output logic [ID_WIDTH-1:0]   mem_req_id_o,

    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [ID_WIDTH-1:0]   mem_resp_id_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
    input  logic                  mem_resp_last_i,
    input  logic                  mem_resp_error_i,

    output logic                  resp0_valid_o,
    input  logic                  resp0_ready_i,
    output logic [ID_WIDTH-2:0]   resp0_id_o,
    output logic [DATA_WIDTH-1:0] resp0_data_o,
    output logic                  resp0_last_o,
    output logic                  resp0_error_o,

    output logic                  resp1_valid_o,
    input  logic                  resp1_ready_i,
    output logic [ID_WIDTH-2:0]   resp1_id_o,
    output logic [DATA_WIDTH-1:0] resp1_data_o,
    output logic                  resp1_last_o,
    output logic                  resp1_error_o,

    output logic                  idle_o,
    output logic                  err_o
);

    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_OUTSTANDING);

    logic [1:0]            elig;
    logic [1:0]            grant;
    logic [1:0]            fire;
    logic [1:0]            dec;
    logic [1:0]            underflow;
    logic                  slot_free;
    logic                  resp_sel;
    logic                  resp_last_fire;

    logic [CntWidth-1:0]   cnt_q [2];
    logic [CntWidth-1:0]   cnt_d [2];
    logic                  rr_q;
    logic                  err_q;

    logic                  mem_req_valid_q;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q;
    logic [7:0]            mem_req_len_q;
    logic [2:0]            mem_req_size_q;
    logic [ID_WIDTH-1:0]   mem_req_id_q;

    logic [ADDR_WIDTH-1:0] load_addr;
    logic [7:0]            load_len;
    logic [2:0]            load_size;
    logic [ID_WIDTH-1:0]   load_id;

    // Eligibility, round-robin grant and request handshakes
    always_comb begin
        elig[0]      = req0_valid_i & (cnt_q[0] < CntMax);
        elig[1]      = req1_valid_i & (cnt_q[1] < CntMax);
        slot_free    = ~mem_req_valid_q | mem_req_ready_i;
        grant[0]     = elig[0] & (~elig[1] | ~rr_q);
        grant[1]     = elig[1] & (~elig[0] | rr_q);
        fire         = grant & {2{slot_free}};
        req0_ready_o = fire[0];
        req1_ready_o = fire[1];
    end

    // Payload selected for the output stage; only one requester fires at a time
    always_comb begin
        if (fire[1]) begin
            load_addr = req1_addr_i;
            load_len  = req1_len_i;
            load_size = req1_size_i;
            load_id   = {1'b1, req1_id_i};
        end else begin
            load_addr = req0_addr_i;
            load_len  = req0_len_i;
            load_size = req0_size_i;
            load_id   = {1'b0, req0_id_i};
        end
    end

    // Response routing by ID MSB; zero latency pass-through
    always_comb begin
        resp_sel         = mem_resp_id_i[ID_WIDTH-1];
        resp0_valid_o    = mem_resp_valid_i & ~resp_sel;
        resp1_valid_o    = mem_resp_valid_i & resp_sel;
        mem_resp_ready_o = resp_sel ? resp1_ready_i : resp0_ready_i;
        resp0_id_o       = mem_resp_id_i[ID_WIDTH-2:0];
        resp1_id_o       = mem_resp_id_i[ID_WIDTH-2:0];
        resp0_data_o     = mem_resp_data_i;
        resp1_data_o     = mem_resp_data_i;
        resp0_last_o     = mem_resp_last_i;
        resp1_last_o     = mem_resp_last_i;
        resp0_error_o    = mem_resp_error_i;
        resp1_error_o    = mem_resp_error_i;
        resp_last_fire   = mem_resp_valid_i & mem_resp_ready_o & mem_resp_last_i;
        dec[0]           = resp_last_fire & ~resp_sel;
        dec[1]           = resp_last_fire & resp_sel;
    end

    // Outstanding counter next state; a completion with nothing in flight is
    // dropped (counter stays put) and reported as an underflow
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            underflow[n] = dec[n] & (cnt_q[n] == '0);
            cnt_d[n]     = cnt_q[n] + CntWidth'(fire[n])
                           - CntWidth'(dec[n] & ~underflow[n]);
        end
    end

    // Counters, round-robin pointer and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            rr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            if (|fire) begin
                rr_q <= fire[0];
            end
            if (|underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    // 1-entry output stage; drain and reload may happen in the same cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_len_q   <= '0;
            mem_req_size_q  <= '0;
            mem_req_id_q    <= '0;
        end else if (slot_free) begin
            mem_req_valid_q <= |fire;
            if (|fire) begin
                mem_req_addr_q <= load_addr;
                mem_req_len_q  <= load_len;
                mem_req_size_q <= load_size;
                mem_req_id_q   <= load_id;
            end
        end
    end

    // Registered outputs and status
    always_comb begin
        mem_req_valid_o = mem_req_valid_q;
        mem_req_addr_o  = mem_req_addr_q;
        mem_req_len_o   = mem_req_len_q;
        mem_req_size_o  = mem_req_size_q;
        mem_req_id_o    = mem_req_id_q;
        idle_o          = ~mem_req_valid_q & (cnt_q[0] == '0) & (cnt_q[1] == '0);
        err_o           = err_q;
    end

endmodule

// File: tb/tb_hpdc_mem_req_arbiter.sv
// Self-checking bench for hpdc_mem_req_arbiter: directed scenarios followed
// by random traffic, all checked against a transaction-level model that
// keeps the in-flight local IDs per requester in queues.
module tb_hpdc_mem_req_arbiter;

    localparam int unsigned AW   = 40;
    localparam int unsigned IW   = 8;
    localparam int unsigned DW   = 64;
    localparam int unsigned MAXO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [7:0]    req0_len, req1_len;
    logic [2:0]    req0_size, req1_size;
    logic [IW-2:0] req0_id, req1_id;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic [7:0]    mem_req_len;
    logic [2:0]    mem_req_size;
    logic [IW-1:0] mem_req_id;
    logic          mem_resp_valid, mem_resp_ready, mem_resp_last, mem_resp_error;
    logic [IW-1:0] mem_resp_id;
    logic [DW-1:0] mem_resp_data;
    logic          resp0_valid, resp0_ready, resp0_last, resp0_error;
    logic          resp1_valid, resp1_ready, resp1_last, resp1_error;
    logic [IW-2:0] resp0_id, resp1_id;
    logic [DW-1:0] resp0_data, resp1_data;
    logic          idle, err;

    always #5 clk = ~clk;

    hpdc_mem_req_arbiter #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_addr_i(req0_addr),
        .req0_len_i(req0_len), .req0_size_i(req0_size), .req0_id_i(req0_id),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_addr_i(req1_addr),
        .req1_len_i(req1_len), .req1_size_i(req1_size), .req1_id_i(req1_id),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_len_o(mem_req_len),
        .mem_req_size_o(mem_req_size), .mem_req_id_o(mem_req_id),
        .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready),
        .mem_resp_id_i(mem_resp_id), .mem_resp_data_i(mem_resp_data),
        .mem_resp_last_i(mem_resp_last), .mem_resp_error_i(mem_resp_error),
        .resp0_valid_o(resp0_valid), .resp0_ready_i(resp0_ready), .resp0_id_o(resp0_id),
        .resp0_data_o(resp0_data), .resp0_last_o(resp0_last), .resp0_error_o(resp0_error),
        .resp1_valid_o(resp1_valid), .resp1_ready_i(resp1_ready), .resp1_id_o(resp1_id),
        .resp1_data_o(resp1_data), .resp1_last_o(resp1_last), .resp1_error_o(resp1_error),
        .idle_o(idle), .err_o(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: pending output request, in-flight IDs per requester
    bit            m_pend;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;
    logic [2:0]    m_size;
    logic [IW-1:0] m_id;
    int            m_prio;
    bit            m_err;
    logic [IW-2:0] oq0[$];
    logic [IW-2:0] oq1[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; mem_req_ready = 0;
        req0_addr = '0; req1_addr = '0; req0_len = '0; req1_len = '0;
        req0_size = '0; req1_size = '0; req0_id = '0; req1_id = '0;
        mem_resp_valid = 0; mem_resp_id = '0; mem_resp_data = '0;
        mem_resp_last = 0; mem_resp_error = 0; resp0_ready = 0; resp1_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        m_pend = 0; m_addr = '0; m_len = '0; m_size = '0; m_id = '0;
        m_prio = 0; m_err = 0;
        oq0.delete(); oq1.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Remove one completed transaction of requester r; false if none in flight
    function automatic bit retire(input int r, input logic [IW-2:0] lid);
        if (r == 0) begin
            if (oq0.size() == 0) return 0;
            foreach (oq0[i]) if (oq0[i] == lid) begin oq0.delete(i); return 1; end
            void'(oq0.pop_front());
        end else begin
            if (oq1.size() == 0) return 0;
            foreach (oq1[i]) if (oq1[i] == lid) begin oq1.delete(i); return 1; end
            void'(oq1.pop_front());
        end
        return 1;
    endfunction

    // One clock cycle: inputs were set at the preceding negedge
    task automatic step();
        bit e0, e1, slot, rsel, rready;
        int g;
        #1;
        check("mem_req_valid", 64'(mem_req_valid), 64'(m_pend));
        check("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
        check("mem_req_len", 64'(mem_req_len), 64'(m_len));
        check("mem_req_size", 64'(mem_req_size), 64'(m_size));
        check("mem_req_id", 64'(mem_req_id), 64'(m_id));
        check("idle", 64'(idle), 64'(!m_pend && oq0.size() == 0 && oq1.size() == 0));
        check("err", 64'(err), 64'(m_err));

        e0 = req0_valid && (oq0.size() < MAXO);
        e1 = req1_valid && (oq1.size() < MAXO);
        slot = !m_pend || mem_req_ready;
        g = -1;
        if (e0 && e1) g = m_prio;
        else if (e0) g = 0;
        else if (e1) g = 1;
        check("req0_ready", 64'(req0_ready), 64'(g == 0 && slot));
        check("req1_ready", 64'(req1_ready), 64'(g == 1 && slot));

        rsel = mem_resp_id[IW-1];
        rready = rsel ? resp1_ready : resp0_ready;
        check("resp0_valid", 64'(resp0_valid), 64'(mem_resp_valid && !rsel));
        check("resp1_valid", 64'(resp1_valid), 64'(mem_resp_valid && rsel));
        check("mem_resp_ready", 64'(mem_resp_ready), 64'(rready));
        if (mem_resp_valid) begin
            check("resp_id", 64'(rsel ? resp1_id : resp0_id), 64'(mem_resp_id[IW-2:0]));
            check("resp_data", 64'(rsel ? resp1_data : resp0_data), 64'(mem_resp_data));
            check("resp_last", 64'(rsel ? resp1_last : resp0_last), 64'(mem_resp_last));
            check("resp_error", 64'(rsel ? resp1_error : resp0_error), 64'(mem_resp_error));
        end

        @(posedge clk);
        if (mem_resp_valid && rready && mem_resp_last) begin
            if (!retire(int'(rsel), mem_resp_id[IW-2:0])) m_err = 1;
        end
        if (slot) begin
            m_pend = (g >= 0);
            if (g == 0) begin
                m_addr = req0_addr; m_len = req0_len; m_size = req0_size;
                m_id = {1'b0, req0_id}; oq0.push_back(req0_id); m_prio = 1;
            end else if (g == 1) begin
                m_addr = req1_addr; m_len = req1_len; m_size = req1_size;
                m_id = {1'b1, req1_id}; oq1.push_back(req1_id); m_prio = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        bit s;
        req0_valid = ($urandom_range(0, 2) != 0);
        req1_valid = ($urandom_range(0, 2) != 0);
        req0_addr = {$urandom, $urandom}; req1_addr = {$urandom, $urandom};
        req0_len = 8'($urandom); req1_len = 8'($urandom);
        req0_size = 3'($urandom); req1_size = 3'($urandom);
        req0_id = 7'($urandom); req1_id = 7'($urandom);
        mem_req_ready = ($urandom_range(0, 9) < 7);
        resp0_ready = $urandom_range(0, 1); resp1_ready = $urandom_range(0, 1);
        mem_resp_data = {$urandom, $urandom};
        mem_resp_error = ($urandom_range(0, 7) == 0);
        s = $urandom_range(0, 1);
        if (s == 0 && oq0.size() > 0 && $urandom_range(0, 1) == 1) begin
            mem_resp_valid = 1;
            mem_resp_id = {1'b0, oq0[$urandom_range(0, oq0.size() - 1)]};
            mem_resp_last = ($urandom_range(0, 2) == 0);
        end else if (s == 1 && oq1.size() > 0 && $urandom_range(0, 1) == 1) begin
            mem_resp_valid = 1;
            mem_resp_id = {1'b1, oq1[$urandom_range(0, oq1.size() - 1)]};
            mem_resp_last = ($urandom_range(0, 2) == 0);
        end else begin
            mem_resp_valid = ($urandom_range(0, 3) == 0);
            mem_resp_id = {s, 7'($urandom)};
            mem_resp_last = 0;
        end
    endtask

    initial begin
        int beat;
        bit fired;
        do_reset();
        #1;
        check("reset_idle", 64'(idle), 64'd1);
        check("reset_err", 64'(err), 64'd0);
        check("reset_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clk);

        // Single requests from each side
        mem_req_ready = 1;
        req0_valid = 1; req0_addr = 40'h80_0000_40; req0_id = 7'h05; req0_len = 0; req0_size = 6;
        step();
        req0_valid = 0;
        check("t1_valid", 64'(mem_req_valid), 64'd1);
        check("t1_id0", 64'(mem_req_id), 64'h05);
        check("t1_addr", 64'(mem_req_addr), 64'h80_0000_40);
        req1_valid = 1; req1_id = 7'h12; req1_addr = 40'h12_3456_00;
        step();
        req1_valid = 0;
        check("t1_id1", 64'(mem_req_id), 64'h92);
        step();

        // Both held valid: alternate grants, one per cycle
        do_reset();
        mem_req_ready = 1; req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req0_id = 7'(i); req1_id = 7'(i + 16);
            step();
            check("t2_valid", 64'(mem_req_valid), 64'd1);
            check("t2_owner", 64'(mem_req_id[IW-1]), 64'(i % 2));
        end

        // Backpressure holds the output stage
        do_reset();
        req0_valid = 1; req0_id = 7'h21; req0_addr = 40'hAB_CDEF_0000;
        step();
        req1_valid = 1; req1_id = 7'h33;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_r0", 64'(req0_ready), 64'd0);
            check("t3_hold_id", 64'(mem_req_id), 64'h21);
        end
        mem_req_ready = 1;
        #1;
        check("t3_reload_r1", 64'(req1_ready), 64'd1);
        step();
        check("t3_next_id", 64'(mem_req_id), 64'hB3);
        clear_inputs();
        step();

        // Outstanding limit on requester 0
        do_reset();
        mem_req_ready = 1; req0_valid = 1;
        for (int i = 0; i < 8; i++) begin
            req0_id = 7'(i);
            step();
        end
        req1_valid = 1; req1_id = 7'h40;
        #1;
        check("t4_r0_blocked", 64'(req0_ready), 64'd0);
        check("t4_r1_served", 64'(req1_ready), 64'd1);
        step();
        req1_valid = 0;
        mem_resp_valid = 1; mem_resp_id = 8'h03; mem_resp_last = 1; resp0_ready = 1;
        step();
        mem_resp_valid = 0;
        #1;
        check("t4_r0_resumed", 64'(req0_ready), 64'd1);
        step();

        // Multi-beat response to requester 1 with toggling ready
        do_reset();
        mem_req_ready = 1; req1_valid = 1; req1_id = 7'h03;
        step();
        req1_valid = 0;
        step();
        beat = 0;
        for (int c = 0; c < 16 && beat < 4; c++) begin
            mem_resp_valid = 1; mem_resp_id = 8'h83; mem_resp_last = (beat == 3);
            mem_resp_data = {$urandom, $urandom}; resp1_ready = (c % 2 == 0);
            fired = resp1_ready;
            #1;
            check("t5_r0_quiet", 64'(resp0_valid), 64'd0);
            check("t5_r1_id", 64'(resp1_id), 64'h03);
            step();
            if (fired) beat++;
        end
        check("t5_beats", 64'(beat), 64'd4);
        mem_resp_valid = 0;
        step();
        check("t5_idle", 64'(idle), 64'd1);

        // Completion with nothing outstanding
        do_reset();
        mem_resp_valid = 1; mem_resp_id = 8'h01; mem_resp_last = 1; resp0_ready = 1;
        #1;
        check("t6_delivered", 64'(resp0_valid), 64'd1);
        step();
        mem_resp_valid = 0;
        check("t6_err", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) step();
        check("t6_err_sticky", 64'(err), 64'd1);
        do_reset();
        #1;
        check("t6_err_cleared", 64'(err), 64'd0);
        @(negedge clk);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_cycle();
            step();
        end

        // Reset with transactions in flight, then a late completion
        clear_inputs();
        mem_req_ready = 1; req0_valid = 1; req0_id = 7'h11;
        step();
        step();
        do_reset();
        mem_resp_valid = 1; mem_resp_id = 8'h11; mem_resp_last = 1; resp0_ready = 1;
        step();
        mem_resp_valid = 0;
        check("t7_late_err", 64'(err), 64'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
